// File: rtl/ift_mt_fetch_tag_pkg.sv
// Shared types and helpers for the multi-thread fetch tag stage.
// Types are sized for the default configuration; the RTL derives its own widths from parameters.
package ift_mt_fetch_tag_pkg;
  localparam int IFT_NUM_THREADS = 4;
  localparam int IFT_NUM_WAYS    = 4;
  localparam int IFT_NUM_SETS    = 64;
  localparam int IFT_LINE_BYTES  = 64;
  localparam int IFT_SET_BITS    = $clog2(IFT_NUM_SETS);
  localparam int IFT_OFF_BITS    = $clog2(IFT_LINE_BYTES);
  localparam int IFT_TAG_WIDTH   = 32 - IFT_SET_BITS - IFT_OFF_BITS;
  localparam logic [31:0] IFT_PC_STEP = 32'd4;

  typedef logic [$clog2(IFT_NUM_THREADS)-1:0] ift_thread_idx_t;
  typedef logic [$clog2(IFT_NUM_WAYS)-1:0]    ift_way_idx_t;
  typedef logic [IFT_SET_BITS-1:0]            ift_set_idx_t;
  typedef logic [IFT_TAG_WIDTH-1:0]           ift_tag_t;

  // Generic PC field extract: width bits starting at lsb, right-aligned.
  function automatic logic [31:0] ift_field(input logic [31:0] pc, input int lsb, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    return (pc >> lsb) & mask;
  endfunction

  function automatic ift_set_idx_t ift_pc_set(input logic [31:0] pc);
    return ift_set_idx_t'(ift_field(pc, IFT_OFF_BITS, IFT_SET_BITS));
  endfunction

  function automatic ift_tag_t ift_pc_tag(input logic [31:0] pc);
    return ift_tag_t'(ift_field(pc, 32 - IFT_TAG_WIDTH, IFT_TAG_WIDTH));
  endfunction
endpackage

// File: rtl/ift_mt_fetch_tag_arb.sv
// Round-robin arbiter: grants the lowest requester at/after the pointer, pointer moves past the winner.
module ift_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // N is a power of two, so IW-bit addition wraps the search around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IW'(i);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ptr <= '0;
    else if (grant_any) ptr <= grant_idx + 1'b1;
  end
endmodule

// File: rtl/ift_mt_fetch_tag.sv
// Multi-thread I-fetch tag stage: RR thread pick, PC/miss-wait tracking, tag/valid arrays, fill victim.
// Optional IFT_PERF_COUNTERS_EN adds saturating fetch/miss counters.
module ift_mt_fetch_tag
  import ift_mt_fetch_tag_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int LINE_BYTES  = 64,
  parameter int TAG_WIDTH   = 32 - $clog2(NUM_SETS) - $clog2(LINE_BYTES),
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int TIW = $clog2(NUM_THREADS),
  localparam int WW  = $clog2(NUM_WAYS),
  localparam int SW  = $clog2(NUM_SETS),
  localparam int OW  = $clog2(LINE_BYTES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_THREADS-1:0]        ts_fetch_en_mask,
  input  logic                          ifd_cache_miss,
  input  logic [TIW-1:0]                ifd_cache_miss_thread,
  input  logic [31:0]                   ifd_cache_miss_pc,
  input  logic                          l2i_wakeup_en,
  input  logic [TIW-1:0]                l2i_wakeup_thread,
  input  logic                          l2i_fill_en,
  input  logic [SW-1:0]                 l2i_fill_set,
  input  logic [TAG_WIDTH-1:0]          l2i_fill_tag,
  output logic [WW-1:0]                 ift_fill_way,
  input  logic                          wb_rollback_en,
  input  logic [TIW-1:0]                wb_rollback_thread,
  input  logic [31:0]                   wb_rollback_pc,
  output logic                          ift_valid,
  output logic [TIW-1:0]                ift_thread_idx,
  output logic [31:0]                   ift_pc,
  output logic [NUM_WAYS*TAG_WIDTH-1:0] ift_tags,
  output logic [NUM_WAYS-1:0]           ift_way_valid
`ifdef IFT_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   ift_perf_fetch_cnt,
  output logic [31:0]                   ift_perf_miss_cnt
`endif
);
  logic [NUM_THREADS-1:0] rb_hot, miss_hot, wake_hot, wait_mask, eligible, grant;
  logic [TIW-1:0]         grant_idx;
  logic                   grant_any;
  logic [31:0]            pc_q [NUM_THREADS];
  logic [31:0]            sel_pc;
  logic [SW-1:0]          sel_set;
  logic [WW-1:0]          victim [NUM_SETS];
  logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tags;
  logic [NUM_WAYS-1:0]    rd_vld;

  always_comb begin
    rb_hot   = '0;
    miss_hot = '0;
    wake_hot = '0;
    if (wb_rollback_en) rb_hot[wb_rollback_thread]     = 1'b1;
    if (ifd_cache_miss) miss_hot[ifd_cache_miss_thread] = 1'b1;
    if (l2i_wakeup_en)  wake_hot[l2i_wakeup_thread]     = 1'b1;
  end

  // Threads being redirected this cycle must not fetch from their stale PC.
  assign eligible = ts_fetch_en_mask & ~wait_mask & ~rb_hot & ~miss_hot;

  ift_rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_pc  = pc_q[grant_idx];
  assign sel_set = SW'(ift_field(sel_pc, OW, SW));

  // Rollback beats miss beats sequential advance; miss beats a same-cycle wakeup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
      wait_mask <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (rb_hot[t])        pc_q[t] <= wb_rollback_pc;
        else if (miss_hot[t]) pc_q[t] <= ifd_cache_miss_pc;
        else if (grant[t])    pc_q[t] <= pc_q[t] + IFT_PC_STEP;
        if (rb_hot[t])        wait_mask[t] <= 1'b0;
        else if (miss_hot[t]) wait_mask[t] <= 1'b1;
        else if (wake_hot[t]) wait_mask[t] <= 1'b0;
      end
    end
  end

  assign ift_fill_way = victim[l2i_fill_set];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) victim[s] <= '0;
    end else if (l2i_fill_en) begin
      victim[l2i_fill_set] <= victim[l2i_fill_set] + 1'b1;
    end
  end

  // Per-way tag/valid storage; reads are combinational and captured by the output register,
  // so a same-cycle fill is only seen by the next read (read-first).
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [TAG_WIDTH-1:0] tag_mem [NUM_SETS];
    logic [NUM_SETS-1:0]  vld_mem;
    logic                 wr;

    assign wr = l2i_fill_en && (ift_fill_way == WW'(w));

    always_ff @(posedge clk) begin
      if (wr) tag_mem[l2i_fill_set] <= l2i_fill_tag;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)   vld_mem <= '0;
      else if (wr) vld_mem[l2i_fill_set] <= 1'b1;
    end

    assign rd_tags[w*TAG_WIDTH +: TAG_WIDTH] = tag_mem[sel_set];
    assign rd_vld[w] = vld_mem[sel_set];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ift_valid      <= 1'b0;
      ift_thread_idx <= '0;
      ift_pc         <= '0;
      ift_tags       <= '0;
      ift_way_valid  <= '0;
    end else begin
      ift_valid <= grant_any;
      if (grant_any) begin
        ift_thread_idx <= grant_idx;
        ift_pc         <= sel_pc;
        ift_tags       <= rd_tags;
        ift_way_valid  <= rd_vld;
      end
    end
  end

`ifdef IFT_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ift_perf_fetch_cnt <= '0;
      ift_perf_miss_cnt  <= '0;
    end else begin
      if (grant_any && ift_perf_fetch_cnt != 32'hFFFF_FFFF)
        ift_perf_fetch_cnt <= ift_perf_fetch_cnt + 32'd1;
      if (ifd_cache_miss && ift_perf_miss_cnt != 32'hFFFF_FFFF)
        ift_perf_miss_cnt <= ift_perf_miss_cnt + 32'd1;
    end
  end
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_grant_elig:   assert property (@(posedge clk) disable iff (reset) (grant & ~eligible) == '0);
  a_grant_en:     assert property (@(posedge clk) disable iff (reset) (grant & ~ts_fetch_en_mask) == '0);
endmodule
